// File: rtl/icache.sv
// Direct-mapped instruction cache: 32 lines of 8 words, single outstanding block refill.
// Hits return the word combinationally; misses stall until memory delivers the whole line.
module icache (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         Fetch_IN,
    input  logic [31:0]  Address_IN,
    input  logic         Flush_IN,
    output logic [31:0]  Instruction_OUT,
    output logic         Stall_OUT,
    output logic [31:0]  MemBlockAddress_OUT,
    output logic         MemBlockRead_OUT,
    input  logic         MemBlockReady_IN,
    input  logic [255:0] InstructionBlock_IN,
    output logic [31:0]  HitCount_OUT,
    output logic [31:0]  MissCount_OUT
);

    typedef enum logic {IDLE, MISS} stateT;

    stateT        state;
    logic [31:0]  valid;
    logic [21:0]  tagMem  [32];
    logic [255:0] dataMem [32];

    logic [2:0]   offset;
    logic [4:0]   index;
    logic [21:0]  tag;
    logic [4:0]   fillIndex;
    logic [21:0]  fillTag;
    logic         hit;
    logic         fillEn;
    logic         unusedAddrBits;

    function automatic logic [31:0] satInc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    assign offset         = Address_IN[4:2];
    assign index          = Address_IN[9:5];
    assign tag            = Address_IN[31:10];
    assign unusedAddrBits = ^Address_IN[1:0];

    // The pending line's index and tag live in the latched refill address.
    assign fillIndex = MemBlockAddress_OUT[9:5];
    assign fillTag   = MemBlockAddress_OUT[31:10];

    assign hit = (state == IDLE) && Fetch_IN && valid[index] && (tagMem[index] == tag);
    // RESET gating keeps an edge that lands during reset from writing the arrays.
    assign fillEn = (state == MISS) && MemBlockReady_IN && RESET;

    always_comb begin
        Instruction_OUT = 32'h0;
        if (hit)
            Instruction_OUT = dataMem[index][{offset, 5'b0} +: 32];
    end

    assign Stall_OUT = (state == MISS) || (Fetch_IN && !hit);

    always_ff @(posedge CLOCK) begin
        if (fillEn) begin
            tagMem[fillIndex]  <= fillTag;
            dataMem[fillIndex] <= InstructionBlock_IN;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state               <= IDLE;
            valid               <= '0;
            MemBlockRead_OUT    <= 1'b0;
            MemBlockAddress_OUT <= 32'h0;
            HitCount_OUT        <= 32'h0;
            MissCount_OUT       <= 32'h0;
        end else begin
            // Later bit write overrides the flush clear, so a coincident fill survives.
            if (Flush_IN)
                valid <= '0;
            if (fillEn)
                valid[fillIndex] <= 1'b1;

            case (state)
                IDLE: begin
                    if (hit) begin
                        HitCount_OUT <= satInc(HitCount_OUT);
                    end else if (Fetch_IN) begin
                        MemBlockAddress_OUT <= {Address_IN[31:5], 5'b0};
                        MemBlockRead_OUT    <= 1'b1;
                        MissCount_OUT       <= satInc(MissCount_OUT);
                        state               <= MISS;
                    end
                end
                MISS: begin
                    if (MemBlockReady_IN) begin
                        MemBlockRead_OUT <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, sequential hits, conflicts, flush, reset abort.
module tb_icache;

    logic         CLOCK = 1'b0;
    logic         RESET;
    logic         Fetch_IN;
    logic [31:0]  Address_IN;
    logic         Flush_IN;
    logic [31:0]  Instruction_OUT;
    logic         Stall_OUT;
    logic [31:0]  MemBlockAddress_OUT;
    logic         MemBlockRead_OUT;
    logic         MemBlockReady_IN;
    logic [255:0] InstructionBlock_IN;
    logic [31:0]  HitCount_OUT;
    logic [31:0]  MissCount_OUT;

    int checks   = 0;
    int failures = 0;
    int stalls;

    icache dut (
        .CLOCK               (CLOCK),
        .RESET               (RESET),
        .Fetch_IN            (Fetch_IN),
        .Address_IN          (Address_IN),
        .Flush_IN            (Flush_IN),
        .Instruction_OUT     (Instruction_OUT),
        .Stall_OUT           (Stall_OUT),
        .MemBlockAddress_OUT (MemBlockAddress_OUT),
        .MemBlockRead_OUT    (MemBlockRead_OUT),
        .MemBlockReady_IN    (MemBlockReady_IN),
        .InstructionBlock_IN (InstructionBlock_IN),
        .HitCount_OUT        (HitCount_OUT),
        .MissCount_OUT       (MissCount_OUT)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [255:0] mkBlock(input logic [31:0] base);
        logic [255:0] b;
        for (int i = 0; i < 8; i++)
            b[32*i +: 32] = base + 32'(i);
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then changed 1 time unit after it.
    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    // Called mid-cycle while a miss is pending; ready arrives in MISS cycle extra+1.
    task automatic serviceMiss(input logic [255:0] blk, input int extra, input logic flushOnReady,
                               output int nStalls);
        int missCycles = 0;
        nStalls = 0;
        while (Stall_OUT && nStalls < 50) begin
            nStalls++;
            if (MemBlockRead_OUT) missCycles++;
            InstructionBlock_IN = blk;
            MemBlockReady_IN    = MemBlockRead_OUT && (missCycles == extra + 1);
            Flush_IN            = flushOnReady && MemBlockReady_IN;
            step();
            MemBlockReady_IN = 1'b0;
            Flush_IN         = 1'b0;
            #1;
        end
        if (nStalls >= 50) begin
            failures++;
            $display("FAIL refill_timeout observed=stalled expected=refill done");
        end
    endtask

    initial begin
        RESET = 1'b0; Fetch_IN = 1'b0; Address_IN = 32'h0; Flush_IN = 1'b0;
        MemBlockReady_IN = 1'b0; InstructionBlock_IN = '0;
        #12;
        chk("rst_read",  {31'b0, MemBlockRead_OUT}, 32'h0);
        chk("rst_addr",  MemBlockAddress_OUT, 32'h0);
        chk("rst_hits",  HitCount_OUT, 32'h0);
        chk("rst_miss",  MissCount_OUT, 32'h0);
        chk("rst_stall", {31'b0, Stall_OUT}, 32'h0);
        RESET = 1'b1;
        step();

        // Cold miss with ready in the third MISS cycle
        Fetch_IN = 1'b1; Address_IN = 32'h0040_0004;
        #1;
        chk("cold_stall", {31'b0, Stall_OUT}, 32'h1);
        chk("cold_instr0", Instruction_OUT, 32'h0);
        serviceMiss(mkBlock(32'hA000_0000), 2, 1'b0, stalls);
        chk("cold_stalls", 32'(stalls), 32'd4);
        chk("cold_blkaddr", MemBlockAddress_OUT, 32'h0040_0000);
        chk("cold_instr", Instruction_OUT, 32'hA000_0001);
        chk("cold_rd_low", {31'b0, MemBlockRead_OUT}, 32'h0);
        step();
        Fetch_IN = 1'b0;
        #1;
        chk("cold_hits", HitCount_OUT, 32'd1);
        chk("cold_miss", MissCount_OUT, 32'd1);

        // Sequential hits over the whole line
        for (int i = 0; i < 8; i++) begin
            Fetch_IN = 1'b1; Address_IN = 32'h0040_0000 + 32'(4 * i);
            #1;
            chk($sformatf("seq_stall%0d", i), {31'b0, Stall_OUT}, 32'h0);
            chk($sformatf("seq_word%0d", i), Instruction_OUT, 32'hA000_0000 + 32'(i));
            step();
        end
        Fetch_IN = 1'b0;
        #1;
        chk("seq_hits", HitCount_OUT, 32'd9);

        // Ready in IDLE must not touch the array
        InstructionBlock_IN = mkBlock(32'hEEEE_0000); MemBlockReady_IN = 1'b1;
        step();
        MemBlockReady_IN = 1'b0; Fetch_IN = 1'b1; Address_IN = 32'h0040_0010;
        #1;
        chk("idle_ready_word", Instruction_OUT, 32'hA000_0004);
        step();
        Fetch_IN = 1'b0;

        // Conflict on index 0
        Fetch_IN = 1'b1; Address_IN = 32'h0040_0400;
        #1;
        chk("conf_stall", {31'b0, Stall_OUT}, 32'h1);
        serviceMiss(mkBlock(32'hB000_0000), 0, 1'b0, stalls);
        chk("conf_stalls", 32'(stalls), 32'd2);
        chk("conf_instr", Instruction_OUT, 32'hB000_0000);
        step();
        Address_IN = 32'h0040_0000;
        #1;
        chk("conf_evict", {31'b0, Stall_OUT}, 32'h1);
        serviceMiss(mkBlock(32'hA000_0000), 1, 1'b0, stalls);
        chk("conf_stalls2", 32'(stalls), 32'd3);
        step();
        Fetch_IN = 1'b0;
        #1;
        chk("conf_miss", MissCount_OUT, 32'd3);
        chk("conf_hits", HitCount_OUT, 32'd12);

        // Address and fetch change while a refill is outstanding
        Fetch_IN = 1'b1; Address_IN = 32'h0040_0800;
        step();
        Fetch_IN = 1'b0; Address_IN = 32'h0040_001C;
        #1;
        chk("chg_read", {31'b0, MemBlockRead_OUT}, 32'h1);
        chk("chg_addr", MemBlockAddress_OUT, 32'h0040_0800);
        chk("chg_stall", {31'b0, Stall_OUT}, 32'h1);
        serviceMiss(mkBlock(32'hC000_0000), 0, 1'b0, stalls);
        Fetch_IN = 1'b1;
        #1;
        chk("chg_newmiss", {31'b0, Stall_OUT}, 32'h1);
        serviceMiss(mkBlock(32'hA000_0000), 0, 1'b0, stalls);
        chk("chg_instr", Instruction_OUT, 32'hA000_0007);
        step();
        Fetch_IN = 1'b0;
        #1;
        chk("chg_miss", MissCount_OUT, 32'd5);

        // Flush, then flush coincident with the refill edge
        Flush_IN = 1'b1;
        step();
        Flush_IN = 1'b0;
        #1;
        chk("flush_hits", HitCount_OUT, 32'd13);
        chk("flush_miss", MissCount_OUT, 32'd5);
        Fetch_IN = 1'b1; Address_IN = 32'h0040_0008;
        #1;
        chk("flush_stall", {31'b0, Stall_OUT}, 32'h1);
        serviceMiss(mkBlock(32'hD000_0000), 0, 1'b1, stalls);
        chk("flush_fillwins", Instruction_OUT, 32'hD000_0002);
        step();
        Fetch_IN = 1'b0;

        // Reset in the middle of a refill
        Fetch_IN = 1'b1; Address_IN = 32'h0040_0040;
        step();
        chk("rmid_read1", {31'b0, MemBlockRead_OUT}, 32'h1);
        RESET = 1'b0;
        #1;
        chk("rmid_read0", {31'b0, MemBlockRead_OUT}, 32'h0);
        chk("rmid_hits", HitCount_OUT, 32'h0);
        chk("rmid_miss", MissCount_OUT, 32'h0);
        InstructionBlock_IN = mkBlock(32'hF000_0000); MemBlockReady_IN = 1'b1;
        step();
        MemBlockReady_IN = 1'b0;
        RESET = 1'b1;
        #1;
        chk("rmid_again", {31'b0, Stall_OUT}, 32'h1);
        chk("rmid_instr", Instruction_OUT, 32'h0);
        Address_IN = 32'h0040_0008;
        #1;
        chk("rmid_flushed", {31'b0, Stall_OUT}, 32'h1);
        Fetch_IN = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
